// File: rtl/whack_game_core.sv
// Reaction-game controller: lights a pseudo-random lane, times the player's
// response, scores hits and counts misses over a fixed number of rounds.

module whack_lane_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);
   logic btn_q;

   // Edge is registered so buttons never reach an output combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         btn_q <= btn;
         rise  <= btn & ~btn_q;
      end
   end
endmodule

module whack_game_core #(
   parameter int          LANES          = 4,
   parameter int          ROUNDS         = 10,
   parameter int          TIMEOUT_CYCLES = 50_000_000,
   parameter int          GAP_CYCLES     = 12_500_000,
   parameter int          MAX_MISSES     = 0,
   parameter int          SCORE_W        = 8,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LANES-1:0]   buttons,
   output logic [LANES-1:0]   lights,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses,
   output logic [SCORE_W-1:0] round_cnt,
   output logic               busy,
   output logic               done,
   output logic               hit_pulse,
   output logic               miss_pulse
);
   localparam int LW   = $clog2(LANES);
   localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX);

   localparam logic [15:0]        SEED_I   = (SEED == 16'h0) ? 16'h1 : SEED;
   localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]      GAP_LAST = TW'(GAP_CYCLES - 1);
   localparam logic [SCORE_W:0]   ROUNDS_V = (SCORE_W+1)'(ROUNDS);
   localparam logic [SCORE_W:0]   MAXM_V   = (SCORE_W+1)'(MAX_MISSES);
   localparam logic [LW:0]        LANES_V  = (LW+1)'(LANES);
   localparam logic [LANES-1:0]   ONE      = LANES'(1);

   typedef enum logic [2:0] {S_IDLE, S_GEN, S_ARM, S_HIT, S_MISS, S_GAP, S_DONE} state_t;

   state_t             state, nxt;
   logic [15:0]        lfsr;
   logic [TW-1:0]      timer;
   logic [LW-1:0]      lane;
   logic [LW-1:0]      cand;
   logic               cand_ok;
   logic [LANES-1:0]   rise;
   logic [LANES-1:0]   lane_oh;
   logic [SCORE_W-1:0] score_inc, miss_inc, miss_upd;
   logic [SCORE_W:0]   rnd_next;
   logic               last;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      whack_lane_edge u_edge (
         .clk  (clk),
         .rst  (rst),
         .btn  (buttons[i]),
         .rise (rise[i])
      );
   end

   // Out-of-range candidates are rejected; the LFSR supplies a new one next cycle.
   assign cand      = lfsr[LW-1:0];
   assign cand_ok   = ({1'b0, cand} < LANES_V);
   assign lane_oh   = ONE << lane;
   assign score_inc = (&score)  ? score  : score  + SCORE_W'(1);
   assign miss_inc  = (&misses) ? misses : misses + SCORE_W'(1);
   assign miss_upd  = (state == S_MISS) ? miss_inc : misses;
   assign rnd_next  = {1'b0, round_cnt} + (SCORE_W+1)'(1);
   assign last      = (rnd_next == ROUNDS_V) ||
                      ((MAX_MISSES != 0) && ({1'b0, miss_upd} >= MAXM_V));

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) nxt = S_GEN;
         S_GEN:          if (cand_ok) nxt = S_ARM;
         S_ARM: begin
            // A press in the final window cycle beats the timeout.
            if (|rise)                 nxt = (rise == lane_oh) ? S_HIT : S_MISS;
            else if (timer == TO_LAST) nxt = S_MISS;
         end
         S_HIT, S_MISS:  nxt = last ? S_DONE : S_GAP;
         S_GAP:          if (timer == GAP_LAST) nxt = S_GEN;
         default:        nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         lfsr       <= SEED_I;
         timer      <= '0;
         lane       <= '0;
         lights     <= '0;
         score      <= '0;
         misses     <= '0;
         round_cnt  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         state <= nxt;

         if (nxt != state)                         timer <= '0;
         else if (state == S_ARM || state == S_GAP) timer <= timer + TW'(1);

         if (state == S_GEN && cand_ok) lane <= cand;

         lights     <= (nxt == S_ARM) ? ((state == S_GEN) ? (ONE << cand) : lights) : '0;
         busy       <= !(nxt == S_IDLE || nxt == S_DONE);
         done       <= (nxt == S_DONE);
         hit_pulse  <= (nxt == S_HIT);
         miss_pulse <= (nxt == S_MISS);

         if (start && (state == S_IDLE || state == S_DONE)) begin
            score     <= '0;
            misses    <= '0;
            round_cnt <= '0;
         end else if (state == S_HIT) begin
            score     <= score_inc;
            round_cnt <= rnd_next[SCORE_W-1:0];
         end else if (state == S_MISS) begin
            misses    <= miss_inc;
            round_cnt <= rnd_next[SCORE_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_whack_game_core.sv
// Directed-plus-random bench for whack_game_core over three parameter sets,
// checked against a round-level game model with a shadow LFSR.

module tb_whack_game_core;
   localparam int          TO   = 20;
   localparam int          GAP  = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v;
   logic       start;
   logic [3:0] buttons;

   logic [3:0] l0, l1;
   logic [2:0] l2;
   logic [7:0] sc0, sc1, sc2, mi0, mi1, mi2, rc0, rc1, rc2;
   logic       bz0, bz1, bz2, dn0, dn1, dn2, hp0, hp1, hp2, mp0, mp1, mp2;

   whack_game_core #(.LANES(4), .ROUNDS(3), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP),
                     .MAX_MISSES(0), .SCORE_W(8), .SEED(SEED)) u_dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start), .buttons(buttons), .lights(l0),
      .score(sc0), .misses(mi0), .round_cnt(rc0), .busy(bz0), .done(dn0),
      .hit_pulse(hp0), .miss_pulse(mp0));

   whack_game_core #(.LANES(4), .ROUNDS(3), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP),
                     .MAX_MISSES(2), .SCORE_W(8), .SEED(SEED)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start), .buttons(buttons), .lights(l1),
      .score(sc1), .misses(mi1), .round_cnt(rc1), .busy(bz1), .done(dn1),
      .hit_pulse(hp1), .miss_pulse(mp1));

   whack_game_core #(.LANES(3), .ROUNDS(200), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP),
                     .MAX_MISSES(0), .SCORE_W(8), .SEED(SEED)) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .start(start), .buttons(buttons[2:0]), .lights(l2),
      .score(sc2), .misses(mi2), .round_cnt(rc2), .busy(bz2), .done(dn2),
      .hit_pulse(hp2), .miss_pulse(mp2));

   int         sel;
   logic [3:0] o_lights;
   logic [7:0] o_score, o_miss, o_rnd;
   logic       o_busy, o_done, o_hp, o_mp;

   always_comb begin
      case (sel)
         1: begin
            o_lights = l1; o_score = sc1; o_miss = mi1; o_rnd = rc1;
            o_busy = bz1; o_done = dn1; o_hp = hp1; o_mp = mp1;
         end
         2: begin
            o_lights = {1'b0, l2}; o_score = sc2; o_miss = mi2; o_rnd = rc2;
            o_busy = bz2; o_done = dn2; o_hp = hp2; o_mp = mp2;
         end
         default: begin
            o_lights = l0; o_score = sc0; o_miss = mi0; o_rnd = rc0;
            o_busy = bz0; o_done = dn0; o_hp = hp0; o_mp = mp0;
         end
      endcase
   end

   int          vectors, miscompares;
   int          m_lanes, m_rounds, m_maxm, m_score, m_miss, m_rnd;
   logic [15:0] sh;

   function automatic logic [15:0] step(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   // Shadow LFSR follows the selected DUT: held at SEED while its reset is low.
   task automatic tick();
      @(posedge clk);
      sh = rst_v[sel] ? step(sh) : SEED;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_l, input logic e_b,
                          input logic e_d, input logic e_h, input logic e_m);
      chk({tag, ".lights"}, 32'(o_lights), 32'(e_l));
      chk({tag, ".score"},  32'(o_score),  m_score);
      chk({tag, ".misses"}, 32'(o_miss),   m_miss);
      chk({tag, ".rounds"}, 32'(o_rnd),    m_rnd);
      chk({tag, ".busy"},   32'(o_busy),   32'(e_b));
      chk({tag, ".done"},   32'(o_done),   32'(e_d));
      chk({tag, ".hit"},    32'(o_hp),     32'(e_h));
      chk({tag, ".miss"},   32'(o_mp),     32'(e_m));
   endtask

   // Rejection sampling from the spec: first cycle whose low two bits name a valid lane.
   task automatic find_lane(input logic [15:0] x0, output int k, output int lane);
      logic [15:0] x;
      x = x0;
      k = 0;
      while ((int'(x) % 4) >= m_lanes && k < 64) begin
         x = step(x);
         k++;
      end
      lane = int'(x) % 4;
   endtask

   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_score = 0; m_miss = 0; m_rnd = 0;
      chk_all("start", 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // kind: 0 lit lane, 1 no press, 2 wrong lane, 3 lit + another. Entered on first GEN cycle.
   task automatic do_round(input int kind, input int d, input bit noise);
      int         k, lane, oth;
      logic [3:0] lit, mask;
      bit         hit, last;
      find_lane(sh, k, lane);
      chk_all("gen", 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (k + 1) tick();
      lit = 4'(1 << lane);
      chk_all("arm", lit, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("no_lane3", 32'(o_lights[3]), 32'(m_lanes == 4 && lane == 3));
      oth = (lane + 1 + int'($urandom_range(m_lanes - 2))) % m_lanes;
      case (kind)
         0:       mask = lit;
         1:       mask = 4'b0;
         2:       mask = 4'(1 << oth);
         default: mask = lit | 4'(1 << oth);
      endcase
      hit = (kind == 0);
      if (kind == 1) begin
         repeat (TO - 1) tick();
         chk_all("arm_last", lit, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end else begin
         repeat (d) tick();
         buttons = mask;
         tick();
         buttons = 4'b0;
         tick();
      end
      chk_all(hit ? "hit" : "miss", 4'b0, 1'b1, 1'b0, hit, !hit);
      if (hit) m_score++; else m_miss++;
      m_rnd++;
      last = (m_rnd == m_rounds) || (m_maxm != 0 && m_miss >= m_maxm);
      tick();
      chk_all(last ? "done" : "gap", 4'b0, !last, last, 1'b0, 1'b0);
      if (!last) begin
         if (noise) begin
            buttons = 4'($urandom_range(15));
            tick();
            buttons = 4'b0;
            repeat (GAP - 1) tick();
         end else begin
            repeat (GAP) tick();
         end
      end
   endtask

   initial begin
      int k, lane;
      vectors = 0; miscompares = 0;
      sel = 0; rst_v = 3'b000; start = 1'b0; buttons = 4'b0; sh = SEED;
      m_lanes = 4; m_rounds = 3; m_maxm = 0; m_score = 0; m_miss = 0; m_rnd = 0;

      repeat (3) tick();
      chk_all("reset", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_v[0] = 1'b1;
      repeat (3) tick();
      chk_all("idle", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Perfect game, then DONE holds.
      start_game();
      repeat (3) do_round(0, 5, 1'b0);
      repeat (3) tick();
      chk_all("done_hold", 4'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Timeouts, restarted from DONE.
      start_game();
      repeat (3) do_round(1, 0, 1'b0);

      // Lit button held from before ARM, then wrong lane, then lit + other.
      find_lane(step(step(sh)), k, lane);
      buttons = 4'(1 << lane);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_score = 0; m_miss = 0; m_rnd = 0;
      do_round(1, 0, 1'b0);
      buttons = 4'b0;
      do_round(2, 3, 1'b0);
      do_round(3, 7, 1'b0);

      // Reset in the middle of ARM after one hit.
      start_game();
      do_round(0, 2, 1'b0);
      find_lane(sh, k, lane);
      repeat (k + 1) tick();
      chk_all("arm2", 4'(1 << lane), 1'b1, 1'b0, 1'b0, 1'b0);
      rst_v[0] = 1'b0;
      #1;
      m_score = 0; m_miss = 0; m_rnd = 0;
      chk_all("rst_async", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_v[0] = 1'b1;
      tick();
      chk_all("rst_idle", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      start_game();
      do_round(0, 4, 1'b0);

      // Early end on MAX_MISSES=2, then restart from DONE.
      rst_v[0] = 1'b0;
      sel = 1; sh = SEED; m_maxm = 2;
      rst_v[1] = 1'b1;
      repeat (2) tick();
      start_game();
      do_round(1, 0, 1'b0);
      do_round(1, 0, 1'b0);
      chk("early_rounds", 32'(o_rnd), 32'd2);
      start_game();

      // LANES=3 rejection sampling with random play.
      rst_v[1] = 1'b0;
      sel = 2; sh = SEED; m_lanes = 3; m_rounds = 200; m_maxm = 0;
      rst_v[2] = 1'b1;
      repeat (2) tick();
      start_game();
      for (int r = 0; r < 200; r++)
         do_round(int'($urandom_range(3)), int'($urandom_range(17)), 1'($urandom_range(1)));
      repeat (2) tick();
      chk_all("l3_end", 4'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/whack_game_core.md
# whack_game_core

Parametrised reaction-game controller for an N-lane light/button board. It picks a pseudo-random lane, lights it, and times the player's response. It scores hits, counts misses (wrong button, simultaneous presses, timeout) and ends after a configured number of rounds or misses. Score and counters feed the board's seven-segment display logic; buttons arrive already synchronised and debounced.

## Interface
- LANES, 4: number of light/button lanes, ≥2; LW = clog2(LANES).
- ROUNDS, 10: rounds per game, ≥1.
- TIMEOUT_CYCLES, 50_000_000: response window per round in clk cycles, ≥2.
- GAP_CYCLES, 12_500_000: lights-off pause between rounds, ≥1.
- MAX_MISSES, 0: early game end when misses reach this value; 0 disables early end.
- SCORE_W, 8: width of score, misses, round_cnt.
- SEED, 16'hACE1: 16-bit LFSR reset value; 0 is replaced by 1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; starts a game when sampled high in IDLE or DONE.
- buttons  in  LANES  player buttons, active-high.
- lights  out  LANES  one-hot lit lane; all zero outside ARM.
- score  out  SCORE_W  hits this game, saturating.
- misses  out  SCORE_W  misses this game, saturating.
- round_cnt  out  SCORE_W  completed rounds this game.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- hit_pulse  out  1  one-cycle pulse in HIT.
- miss_pulse  out  1  one-cycle pulse in MISS.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in all states, including IDLE. Candidate lane = lfsr[LW-1:0].
- Button edges: btn_q registers buttons each cycle. rise = buttons & ~btn_q. Held buttons never count.
- States: IDLE, GEN, ARM, HIT, MISS, GAP, DONE.
- IDLE: start=1 clears score, misses and round_cnt, then goes to GEN.
- GEN: if the candidate is < LANES, latch it as lane and go to ARM. Otherwise stay in GEN (rejection sampling); the LFSR advances, so a new candidate is tried the next cycle.
- ARM: lights = 1<<lane. The timer runs from 0.
  - rise == 1<<lane → HIT.
  - Any other nonzero rise (wrong lane, or the lit lane plus another) → MISS.
  - No rise and timer == TIMEOUT_CYCLES-1 → MISS.
  - A rise in the timeout cycle takes priority over timeout.
- HIT: hit_pulse=1; score += 1, saturating at all-ones. MISS: miss_pulse=1; misses += 1, saturating.
- Leaving HIT or MISS:
  - round_cnt += 1.
  - If round_cnt+1 == ROUNDS, or (MAX_MISSES != 0 and updated misses ≥ MAX_MISSES) → DONE.
  - Otherwise → GAP.
- GAP: lights off. The timer counts GAP_CYCLES cycles, then the FSM goes to GEN. Button edges during GAP are ignored.
- DONE: done=1; score, misses and round_cnt hold. start=1 clears the counters and goes to GEN, which is a restart.
- start in GEN, ARM, HIT, MISS or GAP is ignored.

## Timing
- Reset (rst=0): state=IDLE, lfsr=SEED, btn_q=0, timer=0, lane=0. All outputs are 0.
- Reset mid-game returns immediately to IDLE with all outputs 0. No partial score is retained.
- Outputs are registered, or decoded from the registered state only. buttons has no combinational path to any output.
- Start latency: start high in IDLE at cycle t gives GEN at t+1. ARM is entered at t+2 at the earliest.
- Response: a button edge at cycle t is detected (rise) at t+1 if ARM. The FSM is in HIT or MISS at t+2. The score or misses update is visible at t+3.
- Timeout: ARM lasts exactly TIMEOUT_CYCLES cycles without a press, then one MISS cycle follows.
- Round period without a press: GEN (≥1 cycle) + TIMEOUT_CYCLES + 1 + GAP_CYCLES.
- The timer is cleared on entry to ARM and on entry to GAP.
- round_cnt never exceeds ROUNDS. DONE is reached in the cycle after the last HIT or MISS.

## Test plan
All scenarios use LANES=4, ROUNDS=3, TIMEOUT_CYCLES=20, GAP_CYCLES=4, MAX_MISSES=0 unless stated.
- Perfect game: reset, pulse start, then press the lit lane 5 cycles into each ARM → 3 hit_pulses. Final state: score=3, misses=0, round_cnt=3, done=1, busy=0, lights=0.
- Timeouts: start with no presses → each ARM lasts 20 cycles, 3 miss_pulses follow, done with score=0, misses=3.
- Wrong and simultaneous presses:
  - Press a non-lit lane → MISS.
  - Press the lit lane plus another lane in the same cycle → MISS.
  - Holding the lit button from before ARM → no hit; the round times out.
- Early end and restart: MAX_MISSES=2; two timeouts → DONE after round 2 with round_cnt=2. Start in DONE → counters clear and GEN is entered the next cycle.
- Reset mid-ARM: assert rst=0 for 1 cycle during ARM after one hit → all outputs 0 and state IDLE. Start after release begins a fresh game with score=0.
- LANES=3 rejection: run 200 rounds with random presses → lights is always one of 001, 010 or 100, never 000 in ARM. The bench checks lane 3 is never selected.
